vctrl_pipe: RTL

Parametrised control pipeline and vector-beat sequencer. It carries the decoded control bundle from decode through `NSTAGES` downstream stages (E, M, W, …), each with its own stall and flush. It also splits vector instructions wider than the datapath into `BEATS = ceil(VLEN/LANES)` consecutive beats, holding decode until the last beat issues. It sits between the main/ALU decoders and the datapath and replaces fixed-depth, fixed-width control registers.

---
 rtl/vctrl_pkg.sv | 19 +
 rtl/vctrl_stage.sv | 14 +
 rtl/vctrl_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/vctrl_pkg.sv
// vctrl_pkg: shared sequencer state type, beat sizing helpers and control bundle field indices
package vctrl_pkg;
  typedef enum logic {IDLE, SEQ} seq_state_t;
  localparam int F_REG_WRITE  = 0;
  localparam int F_MEM_WRITE  = 1;
  localparam int F_MEM_TO_REG = 2;
  localparam int F_ALU_SRC    = 3;
  localparam int F_BRANCH     = 4;
  localparam int F_ALU_CTL    = 5;
  localparam int ALU_CTL_W    = 4;
  function automatic int beats_f(input int vlen, input int lanes);
    int b;
    b = (vlen + lanes - 1) / lanes;
    return b < 1 ? 1 : b;
  endfunction
  function automatic int bw_f(input int beats);
    return beats > 1 ? $clog2(beats) : 1;
  endfunction
endpackage

// File: rtl/vctrl_stage.sv
// vctrl_stage: one pipeline register with load enable and bubble clear
module vctrl_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  // reset and clear both zero the stage; otherwise load when not held
  always_ff @(posedge clk) q <= (!reset || clr) ? '0 : en ? d : q;
endmodule

// File: rtl/vctrl_pipe.sv
// vctrl_pipe: control pipeline with vector beat sequencer; VCTRL_PERF_EN adds perf counters
module vctrl_pipe import vctrl_pkg::*; #(
  parameter  int NSTAGES = 3,
  parameter  int CTRLW   = 24,
  parameter  int VLEN    = 8,
  parameter  int LANES   = 4,
  localparam int BEATS   = beats_f(VLEN, LANES),
  localparam int BW      = bw_f(BEATS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [CTRLW-1:0]         ctrl_d,
  input  logic                     valid_d,
  input  logic                     vec_d,
  input  logic                     kill_d,
  input  logic [NSTAGES-1:0]       stall_i,
  input  logic [NSTAGES-1:0]       flush_i,
  output logic [NSTAGES*CTRLW-1:0] ctrl_o,
  output logic [NSTAGES-1:0]       valid_o,
  output logic [BW-1:0]            beat_e,
  output logic                     last_e,
  output logic                     seq_stall_d
`ifdef VCTRL_PERF_EN
  , output logic [31:0]            perf_instr
  , output logic [31:0]            perf_stall
`endif
);
  localparam int PW = CTRLW + BW + 2;
`ifdef VCTRL_PERF_EN
  localparam int SW = CTRLW + 2;
`else
  localparam int SW = CTRLW + 1;
`endif
  localparam logic [BW-1:0] LASTC = BW'(BEATS - 1);
  seq_state_t         state;
  logic [BW-1:0]      cnt;
  logic [CTRLW-1:0]   lat;
  logic [NSTAGES-1:0] hold;
  logic [PW-1:0]      iss, e_q;
  logic [SW-1:0]      s_q [NSTAGES];
  logic               seq, vstart, advance, last_cnt, iss_valid;
  assign seq       = state == SEQ;
  assign vstart    = valid_d & vec_d & (BEATS > 1);
  assign advance   = ~hold[0] & ~flush_i[0] & ~kill_d;
  assign last_cnt  = cnt == LASTC;
  assign iss_valid = ~kill_d & (seq | valid_d);
  assign iss = {iss_valid, iss_valid & (seq ? last_cnt : ~vstart), seq ? cnt : BW'(0), seq ? lat : ctrl_d};
  assign seq_stall_d = reset & ~kill_d & (seq ? ~(advance & last_cnt) : vstart);
  // beat sequencer: latch the vector bundle on beat 0, count beats on each advance
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      lat   <= '0;
    end else if (state == IDLE) begin
      if (vstart & advance) begin
        state <= SEQ;
        cnt   <= BW'(1);
        lat   <= ctrl_d;
      end
    end else if (kill_d | (advance & last_cnt)) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (advance) cnt <= cnt + BW'(1);
  vctrl_stage #(.W(PW)) u_e (.clk, .reset, .en(~hold[0]), .clr(flush_i[0]), .d(iss), .q(e_q));
  assign beat_e = e_q[CTRLW +: BW];
  assign last_e = e_q[PW-2];
`ifdef VCTRL_PERF_EN
  assign s_q[0] = {e_q[PW-1], e_q[PW-2], e_q[CTRLW-1:0]};
`else
  assign s_q[0] = {e_q[PW-1], e_q[CTRLW-1:0]};
`endif
  for (genvar k = 0; k < NSTAGES; k++) begin : g_out
    assign hold[k] = |stall_i[NSTAGES-1:k];
    assign ctrl_o[k*CTRLW +: CTRLW] = s_q[k][CTRLW-1:0];
    assign valid_o[k] = s_q[k][SW-1];
  end
  for (genvar k = 1; k < NSTAGES; k++) begin : g_st
    vctrl_stage #(.W(SW)) u_st (.clk, .reset, .en(~hold[k]), .clr(flush_i[k]), .d(s_q[k-1]), .q(s_q[k]));
  end
`ifdef VCTRL_PERF_EN
  // count final beats leaving W and cycles where decode or E is held
  always_ff @(posedge clk)
    if (!reset) begin
      perf_instr <= '0;
      perf_stall <= '0;
    end else begin
      if (s_q[NSTAGES-1][SW-1] & s_q[NSTAGES-1][CTRLW] & ~hold[NSTAGES-1]) perf_instr <= perf_instr + 32'd1;
      if (seq_stall_d | hold[0]) perf_stall <= perf_stall + 32'd1;
    end
`endif
endmodule
